// File: rtl/utopia_tx_arbiter.sv
// utopia_tx_arbiter: round-robin, cell-atomic arbiter sharing one UTOPIA Tx port
// among NumSrc first-word-fall-through cell sources.
module utopia_tx_arbiter #(
   parameter int NumSrc    = 4,
   parameter int IfWidth   = 8,
   parameter int CellBytes = 53
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NumSrc-1:0]         src_req,
   input  logic [NumSrc*IfWidth-1:0] src_data,
   output logic [NumSrc-1:0]         src_rd,
   output logic [IfWidth-1:0]        tx_data,
   output logic                      tx_soc,
   output logic                      tx_en,
   input  logic                      tx_clav,
   output logic [NumSrc-1:0]         grant,
   output logic                      cell_done
);
   localparam int IW = $clog2(NumSrc);
   localparam int CW = $clog2(CellBytes);
   localparam logic [CW-1:0] LAST = CW'(CellBytes - 1);
   typedef enum logic {IDLE, XFER} state_t;
   state_t state, state_nxt;
   logic [IW-1:0] rr_ptr, rr_nxt, win, win_nxt, pick, idx;
   logic [CW-1:0] byte_cnt, cnt_nxt;
   logic [NumSrc-1:0] grant_nxt;
   logic [IfWidth-1:0] data_nxt;
   logic soc_nxt, en_nxt, done_nxt, found;
   assign src_rd = (state == XFER) ? grant : '0;
   // first requester at or after rr_ptr, searching circularly upward
   always_comb begin
      pick = rr_ptr;
      idx = '0;
      found = 1'b0;
      for (int o = 0; o < NumSrc; o++) begin
         idx = IW'((int'(rr_ptr) + o) % NumSrc);
         if (!found && src_req[idx]) begin
            found = 1'b1;
            pick = idx;
         end
      end
   end
   always_comb begin
      state_nxt = state;
      rr_nxt = rr_ptr;
      win_nxt = win;
      cnt_nxt = byte_cnt;
      grant_nxt = grant;
      data_nxt = tx_data;
      soc_nxt = 1'b0;
      en_nxt = 1'b1;
      done_nxt = 1'b0;
      if (state == IDLE) begin
         if (found && tx_clav) begin
            state_nxt = XFER;
            win_nxt = pick;
            grant_nxt = NumSrc'(1) << pick;
            cnt_nxt = '0;
         end
      end else begin
         data_nxt = src_data[win*IfWidth +: IfWidth];
         en_nxt = 1'b0;
         soc_nxt = (byte_cnt == '0);
         cnt_nxt = byte_cnt + 1'b1;
         if (byte_cnt == LAST) begin
            done_nxt = 1'b1;
            rr_nxt = (win == IW'(NumSrc - 1)) ? '0 : win + 1'b1;
            grant_nxt = '0;
            cnt_nxt = '0;
            state_nxt = IDLE;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rr_ptr <= '0;
         win <= '0;
         byte_cnt <= '0;
         grant <= '0;
         tx_data <= '0;
         tx_soc <= 1'b0;
         tx_en <= 1'b1;
         cell_done <= 1'b0;
      end else begin
         state <= state_nxt;
         rr_ptr <= rr_nxt;
         win <= win_nxt;
         byte_cnt <= cnt_nxt;
         grant <= grant_nxt;
         tx_data <= data_nxt;
         tx_soc <= soc_nxt;
         tx_en <= en_nxt;
         cell_done <= done_nxt;
      end
   end
endmodule

// File: tb/tb_utopia_tx_arbiter.sv
// tb_utopia_tx_arbiter: cell-timeline model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_utopia_tx_arbiter;
   localparam int N = 4, W = 8, CB = 53;
   logic clk = 1'b0, rst = 1'b1, tx_clav = 1'b1;
   logic [N-1:0] src_req = '0, src_rd, grant;
   logic [N*W-1:0] src_data = '0;
   logic [W-1:0] tx_data;
   logic tx_soc, tx_en, cell_done;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;

   utopia_tx_arbiter #(.NumSrc(N), .IfWidth(W), .CellBytes(CB)) dut (
      .clk(clk), .rst(rst), .src_req(src_req), .src_data(src_data), .src_rd(src_rd),
      .tx_data(tx_data), .tx_soc(tx_soc), .tx_en(tx_en), .tx_clav(tx_clav),
      .grant(grant), .cell_done(cell_done));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // sources: byte queues, head presented on src_data, popped on src_rd
   logic [W-1:0] srcq[N][$];
   logic [N-1:0] rd_s = '0;
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < N; i++) if (rd_s[i] === 1'b1 && srcq[i].size() > 0) void'(srcq[i].pop_front());
      for (int i = 0; i < N; i++) src_data[i*W +: W] = srcq[i].size() > 0 ? srcq[i][0] : '0;
   end

   task automatic load(input int s, input int base);
      for (int k = 0; k < CB; k++) srcq[s].push_back(W'(base + k));
   endtask

   // model: each granted cell decided in cycle s occupies grant/src_rd for s+1..s+CB,
   // tx bytes for s+2..s+CB+1, cell_done at s+CB+1; a new decision is allowed from s+CB+1
   int cyc = 0, rr = 0, run = 0;
   bit sv[2];
   int ss[2], sw[2];
   logic [W-1:0] sc[2][CB];
   int gq[$], runs[$];
   logic [N-1:0] g_prev = '0;
   always @(negedge clk) begin
      logic [N-1:0] eg;
      logic e_en, e_soc, e_done, dchk;
      logic [W-1:0] ed;
      int d, w;
      bit busy;
      eg = '0; e_en = 1'b1; e_soc = 1'b0; e_done = 1'b0; dchk = 1'b0; ed = '0;
      for (int k = 0; k < 2; k++) if (sv[k]) begin
         d = cyc - ss[k];
         if (d >= 1 && d <= CB) eg[sw[k]] = 1'b1;
         if (d >= 2 && d <= CB + 1) begin
            e_en = 1'b0;
            e_soc = (d == 2);
            ed = sc[k][d-2];
            dchk = 1'b1;
         end
         if (d == CB + 1) e_done = 1'b1;
      end
      if (cyc > 0) begin
         chk("grant", grant, eg);
         chk("src_rd", src_rd, eg);
         chk("tx_en", tx_en, e_en);
         chk("tx_soc", tx_soc, e_soc);
         chk("cell_done", cell_done, e_done);
         if (dchk) chk("tx_data", tx_data, ed);
      end
      if (tx_en === 1'b0) run++;
      else if (run > 0) begin
         runs.push_back(run);
         run = 0;
      end
      if (g_prev === '0 && grant !== '0)
         for (int i = 0; i < N; i++) if (grant[i] === 1'b1) gq.push_back(i);
      g_prev = grant;
      rd_s = src_rd;
      if (rst) begin
         sv = '{1'b0, 1'b0};
         rr = 0;
      end else begin
         busy = sv[1] && (cyc - ss[1] < CB + 1);
         if (sv[1] && cyc - ss[1] == CB + 1) rr = (sw[1] + 1) % N;
         if (!busy && src_req != '0 && tx_clav) begin
            w = rr;
            while (!src_req[w]) w = (w + 1) % N;
            sv[0] = sv[1]; ss[0] = ss[1]; sw[0] = sw[1]; sc[0] = sc[1];
            sv[1] = 1'b1; ss[1] = cyc; sw[1] = w;
            for (int k = 0; k < CB; k++) sc[1][k] = k < srcq[w].size() ? srcq[w][k] : '0;
         end
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int n, input string name);
      int seen = 0;
      for (int t = 0; t < 2000 && seen < n; t++) begin
         tick();
         if (cell_done) seen++;
      end
      chk({name, " cells done"}, seen, n);
   endtask

   initial begin
      int g0, r0, rd_hi, en_lo, soc_n, done_n;
      src_req = 4'b1111;
      tx_clav = 1'b1;
      for (int s = 0; s < N; s++) begin
         load(s, s << 6);
         load(s, s << 6);
      end
      repeat (3) begin
         tick();
         chk("rst tx_en", tx_en, 1);
         chk("rst grant", grant, 0);
         chk("rst src_rd", src_rd, 0);
      end
      g0 = gq.size();
      r0 = runs.size();
      rst = 1'b0;
      tick();
      chk("first grant", grant, 4'b0001);
      wait_done(8, "rr");
      src_req = '0;
      repeat (2) tick();
      chk("rr grants", gq.size() - g0, 8);
      for (int i = g0; i < gq.size(); i++) chk("rr order", gq[i], (i - g0) % N);
      chk("rr runs", runs.size() - r0, 8);
      for (int i = r0; i < runs.size(); i++) chk("rr cell length", runs[i], CB);

      for (int s = 0; s < N; s++) begin
         srcq[s].delete();
         load(s, 0);
      end
      src_req = 4'b0100;
      rd_hi = 0; en_lo = 0; soc_n = 0; done_n = 0;
      for (int t = 0; t < 200 && done_n == 0; t++) begin
         tick();
         if (src_rd[2]) rd_hi++;
         if (!tx_en) en_lo++;
         if (tx_soc) begin
            soc_n++;
            chk("soc byte", tx_data, 8'h00);
         end
         if (cell_done) begin
            done_n++;
            chk("last byte", tx_data, 8'h34);
         end
      end
      src_req = '0;
      chk("single rd cycles", rd_hi, CB);
      chk("single en low", en_lo, CB);
      chk("single soc count", soc_n, 1);
      chk("single done count", done_n, 1);
      tick();
      chk("done pulse width", cell_done, 0);

      for (int s = 0; s < N; s++) srcq[s].delete();
      load(1, 8'h80);
      tx_clav = 1'b0;
      src_req = 4'b0010;
      repeat (20) begin
         tick();
         chk("bp tx_en", tx_en, 1);
         chk("bp grant", grant, 0);
      end
      tx_clav = 1'b1;
      tick();
      chk("bp grant", grant, 4'b0010);
      repeat (11) tick();
      chk("bp byte10", tx_data, 8'h8a);
      tx_clav = 1'b0;
      wait_done(1, "bp");
      src_req = '0;
      repeat (2) tick();
      chk("bp cell length", runs.size() > 0 ? runs[runs.size()-1] : 0, CB);
      tx_clav = 1'b1;

      load(1, 8'hc0);
      src_req = 4'b0010;
      tick();
      chk("mid grant", grant, 4'b0010);
      repeat (21) tick();
      chk("mid byte20", tx_data, 8'hd4);
      rst = 1'b1;
      tick();
      chk("mid rst tx_en", tx_en, 1);
      chk("mid rst tx_soc", tx_soc, 0);
      chk("mid rst grant", grant, 0);
      chk("mid rst src_rd", src_rd, 0);
      chk("mid rst done", cell_done, 0);
      tick();
      for (int s = 0; s < N; s++) srcq[s].delete();
      load(0, 8'h40);
      load(1, 8'h60);
      src_req = 4'b0011;
      tick();
      rst = 1'b0;
      tick();
      chk("post rst grant", grant, 4'b0001);
      wait_done(2, "post rst");
      src_req = '0;
      repeat (3) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
